// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one word-wide data-memory transaction per accepted
// request, with byte-lane steering, load extension, misalignment and timeout.
//
// Handshake: mem_req_o rises on the edge that accepts start_i and stays high,
// with mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o stable, until mem_ack_i is
// sampled high on a rising edge (transfer done, mem_rdata_i valid in that same
// cycle) or the timeout expires. mem_ack_i outside a request is ignored.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [5:0]  alucode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  state_o
);

    // Load/store alucodes as numbered in the core's define.vh.
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]  code_q, code_d;
    logic [1:0]  off_q, off_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        is_ls;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    // Decode the incoming request: access class, alignment, lanes and store data.
    always_comb begin
        is_ls      = (alucode_i >= ALU_LB) && (alucode_i <= ALU_SW);
        is_store   = (alucode_i >= ALU_SB) && (alucode_i <= ALU_SW);
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = 32'h0;
        case (alucode_i)
            ALU_LH, ALU_LHU: misaligned = addr_i[0];
            ALU_LW:          misaligned = |addr_i[1:0];
            ALU_SB: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
            end
            ALU_SH: begin
                misaligned = addr_i[0];
                be_new     = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{store_data_i[15:0]}};
            end
            ALU_SW: begin
                misaligned = |addr_i[1:0];
                be_new     = 4'b1111;
                wdata_new  = store_data_i;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half from the read word and extend it per latched code.
    always_comb begin
        rbyte    = mem_rdata_i[{off_q, 3'b000} +: 8];
        rhalf    = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        load_ext = 32'h0;
        case (code_q)
            ALU_LB:  load_ext = {{24{rbyte[7]}}, rbyte};
            ALU_LBU: load_ext = {24'h0, rbyte};
            ALU_LH:  load_ext = {{16{rhalf[15]}}, rhalf};
            ALU_LHU: load_ext = {16'h0, rhalf};
            ALU_LW:  load_ext = mem_rdata_i;
            default: load_ext = 32'h0;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/REQ/FIN sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && is_ls) begin
                    busy_d = 1'b1;
                    if (misaligned) begin
                        state_d     = S_FIN;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        code_d      = alucode_i;
                        off_d       = addr_i[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr_i[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_d     = S_FIN;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    load_data_d = load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_FIN;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    load_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b0;
                err_d       = 1'b0;
                load_data_d = 32'h0;
                cnt_d       = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= 6'h0;
            off_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign load_data_o = load_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign state_o     = state_q;

endmodule
